// File: rtl/gearbox_n_to_32.sv
// gearbox_n_to_32: TX gearbox that repacks MSB-first IN_WIDTH-bit words
// into LSB-first 32-bit words for the transceiver TX user data port.
// Ports:
//   clk, rst       - TX user clock, async active-high reset
//   data_in        - IN_WIDTH-bit input word, bit IN_WIDTH-1 sent first
//   valid_in/ready - input handshake (ready is combinational)
//   tx_ce          - transceiver takes one output word this cycle
//   data_out       - registered 32-bit word, bit 0 sent first
//   valid_out      - data_out carries real data (not idle fill)
//   underrun       - pulse: tx_ce seen with fewer than 32 bits buffered
// Optional (macro GEARBOX_N_TO_32_STATS_EN):
//   stats_clear    - synchronous clear of underrun_count
//   underrun_count - saturating 16-bit count of underrun pulses
module gearbox_n_to_32 #(
  parameter int          IN_WIDTH  = 40,
  parameter int          OUT_WIDTH = 32,
  parameter logic [31:0] IDLE_WORD = 32'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_WIDTH-1:0] data_in,
  input  logic                valid_in,
  output logic                ready,
  input  logic                tx_ce,
  output logic [31:0]         data_out,
  output logic                valid_out,
  output logic                underrun
`ifdef GEARBOX_N_TO_32_STATS_EN
  ,
  input  logic                stats_clear,
  output logic [15:0]         underrun_count
`endif
);

  localparam int CAP = IN_WIDTH + 31;
  localparam int WW  = $clog2(CAP + 1);
  localparam logic [WW-1:0] W32 = WW'(32);
  localparam logic [WW-1:0] WIN = WW'(IN_WIDTH);

  generate
    if (OUT_WIDTH != 32) begin : g_bad_out
      $error("gearbox_n_to_32: OUT_WIDTH must be 32");
    end
    if (IN_WIDTH < 33 || IN_WIDTH > 64) begin : g_bad_in
      $error("gearbox_n_to_32: IN_WIDTH must be 33..64");
    end
  endgenerate

  // buffer is MSB-justified: the oldest bit sits at buffer[CAP-1]
  logic [CAP-1:0] buffer;
  logic [CAP-1:0] buffer_next;
  logic [CAP-1:0] shifted;
  logic [CAP-1:0] placed;
  logic [CAP-1:0] mask;
  logic [WW-1:0]  work_valid;
  logic [WW-1:0]  rem;
  logic [WW-1:0]  wv_next;
  logic [31:0]    top_rev;
  logic           pop;
  logic           accept;

  always_comb begin
    pop     = tx_ce && (work_valid >= W32);
    rem     = pop ? (work_valid - W32) : work_valid;
    ready   = (rem < W32);
    accept  = valid_in && ready;
    wv_next = accept ? (rem + WIN) : rem;
    shifted = pop ? (buffer << 32) : buffer;
    // new word lands directly under the rem bits still held
    placed  = {data_in, 31'b0} >> rem;
    // keep only the top wv_next bits so stale data never resurfaces
    mask    = ~({CAP{1'b1}} >> wv_next);
    buffer_next = (shifted | (accept ? placed : '0)) & mask;
  end

  always_comb begin
    top_rev = '0;
    for (int i = 0; i < 32; i++) begin
      top_rev[i] = buffer[CAP-1-i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buffer     <= '0;
      work_valid <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      buffer     <= buffer_next;
      work_valid <= wv_next;
      underrun   <= tx_ce && !pop;
      if (tx_ce) begin
        data_out  <= pop ? top_rev : IDLE_WORD;
        valid_out <= pop;
      end
    end
  end

`ifdef GEARBOX_N_TO_32_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_count <= '0;
    end else if (stats_clear) begin
      underrun_count <= '0;
    end else if (tx_ce && !pop && (underrun_count != 16'hFFFF)) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gearbox_n_to_32.sv
// tb_gearbox_n_to_32: directed vector table plus bit-queue model
// sequences for the multi-cycle corner cases of gearbox_n_to_32.
module tb_gearbox_n_to_32;

  localparam int          IW   = 40;
  localparam logic [31:0] IDLE = 32'h0F0F_1234;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [IW-1:0] data_in = '0;
  logic          valid_in = 1'b0;
  logic          ready;
  logic          tx_ce = 1'b0;
  logic [31:0]   data_out;
  logic          valid_out;
  logic          underrun;
`ifdef GEARBOX_N_TO_32_STATS_EN
  logic          stats_clear = 1'b0;
  logic [15:0]   underrun_count;
`endif

  gearbox_n_to_32 #(
    .IN_WIDTH (IW),
    .OUT_WIDTH(32),
    .IDLE_WORD(IDLE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready    (ready),
    .tx_ce    (tx_ce),
    .data_out (data_out),
    .valid_out(valid_out),
    .underrun (underrun)
`ifdef GEARBOX_N_TO_32_STATS_EN
    ,
    .stats_clear   (stats_clear),
    .underrun_count(underrun_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  typedef struct {
    logic          vin;
    logic [IW-1:0] din;
    logic          ce;
    logic          rdy;
    logic          vout;
    logic [31:0]   dout;
    logic          und;
  } vec_t;

  vec_t tv[10];

  // reference model: FIFO of bits in transmission order
  bit          q[$];
  logic [31:0] m_dout;
  logic        m_vout;

  task automatic cyc(input logic vin, input logic [IW-1:0] din,
                     input logic ce, input string tag);
    int          sz;
    logic        pop_m;
    logic        rdy_m;
    logic [31:0] w;
    w = '0;
    valid_in = vin;
    data_in  = din;
    tx_ce    = ce;
    #1;
    sz    = q.size();
    pop_m = ce && (sz >= 32);
    rdy_m = ((sz - (pop_m ? 32 : 0)) < 32);
    chk({tag, "/ready"}, 64'(ready), 64'(rdy_m));
    @(posedge clk);
    #1;
    if (pop_m) begin
      for (int i = 0; i < 32; i++) w[i] = q.pop_front();
    end
    if (vin && rdy_m) begin
      for (int i = IW - 1; i >= 0; i--) q.push_back(din[i]);
    end
    if (ce) begin
      m_dout = pop_m ? w : IDLE;
      m_vout = pop_m;
    end
    chk({tag, "/data_out"}, 64'(data_out), 64'(m_dout));
    chk({tag, "/valid_out"}, 64'(valid_out), 64'(m_vout));
    chk({tag, "/underrun"}, 64'(underrun), 64'(ce && !pop_m));
  endtask

  // entered and left at posedge+1
  task automatic do_reset(input string tag);
    rst      = 1'b1;
    valid_in = 1'b0;
    tx_ce    = 1'b0;
    #1;
    chk({tag, "/rst_data_out"}, 64'(data_out), 64'd0);
    chk({tag, "/rst_valid_out"}, 64'(valid_out), 64'd0);
    chk({tag, "/rst_underrun"}, 64'(underrun), 64'd0);
    #2;
    rst = 1'b0;
    q.delete();
    m_dout = '0;
    m_vout = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nvalid;
    logic [IW-1:0] w;

    tv[0] = '{1'b1, 40'h80_0000_0001, 1'b1, 1'b1, 1'b0, IDLE, 1'b1};
    tv[1] = '{1'b1, 40'hFF_00FF_00FF, 1'b1, 1'b1, 1'b1,
              rev32(32'h8000_0000), 1'b0};
    tv[2] = '{1'b1, 40'h01_2345_6789, 1'b1, 1'b1, 1'b1,
              rev32(32'h01FF_00FF), 1'b0};
    tv[3] = '{1'b1, 40'hA5_A5A5_A5A5, 1'b1, 1'b1, 1'b1,
              rev32(32'h00FF_0123), 1'b0};
    tv[4] = '{1'b0, 40'h0, 1'b1, 1'b0, 1'b1,
              rev32(32'h4567_89A5), 1'b0};
    tv[5] = '{1'b0, 40'h0, 1'b1, 1'b1, 1'b1,
              rev32(32'hA5A5_A5A5), 1'b0};
    for (int i = 6; i < 10; i++) begin
      tv[i] = '{1'b0, 40'h0, 1'b1, 1'b1, 1'b0, IDLE, 1'b1};
    end

    #2;
    chk("init/data_out", 64'(data_out), 64'd0);
    chk("init/valid_out", 64'(valid_out), 64'd0);
    chk("init/underrun", 64'(underrun), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // table: 4-word stream, then idle source
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      valid_in = tv[i].vin;
      data_in  = tv[i].din;
      tx_ce    = tv[i].ce;
      #1;
      chk($sformatf("tv%0d/ready", i), 64'(ready), 64'(tv[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("tv%0d/data_out", i), 64'(data_out),
          64'(tv[i].dout));
      chk($sformatf("tv%0d/valid_out", i), 64'(valid_out),
          64'(tv[i].vout));
      chk($sformatf("tv%0d/underrun", i), 64'(underrun),
          64'(tv[i].und));
      if (valid_out) nvalid++;
      if (i == 1) chk("tv1/first_bit", 64'(data_out[0]), 64'd1);
    end
    chk("tv/valid_words", 64'(nvalid), 64'd5);

    // tx_ce toggling with an always-valid source
    do_reset("tog");
    for (int k = 0; k < 20; k++) begin
      w = 40'h01_2345_6789 + IW'(k) * 40'h13_5791_3579;
      cyc(1'b1, w, (k % 2 == 0), $sformatf("tog%0d", k));
      if (k >= 2 && k % 2 == 0)
        chk($sformatf("tog%0d/filled", k), 64'(valid_out), 64'd1);
    end

    // single word then starvation; 8 leftover bits must be kept
    do_reset("starve");
    cyc(1'b1, 40'hC3_5A69_1E2D, 1'b0, "st0");
    cyc(1'b0, 40'h0, 1'b1, "st1");
    chk("st1/word", 64'(data_out), 64'(rev32(32'hC35A_691E)));
    cyc(1'b0, 40'h0, 1'b1, "st2");
    cyc(1'b0, 40'h0, 1'b0, "st3");
    cyc(1'b1, 40'hFF_FFFF_FFFF, 1'b1, "st4");
    cyc(1'b0, 40'h0, 1'b1, "st5");
    chk("st5/word", 64'(data_out), 64'(rev32(32'h2DFF_FFFF)));
    cyc(1'b0, 40'h0, 1'b1, "st6");

    // reset while 24 bits are buffered
    do_reset("mid");
    cyc(1'b1, 40'h11_1111_1111, 1'b1, "mid0");
    cyc(1'b1, 40'h22_2222_2222, 1'b1, "mid1");
    cyc(1'b1, 40'h33_3333_3333, 1'b1, "mid2");
    cyc(1'b0, 40'h0, 1'b1, "mid3");
    do_reset("mid");
    cyc(1'b1, 40'h96_0F3C_5AA5, 1'b1, "mid4");
    cyc(1'b0, 40'h0, 1'b1, "mid5");
    chk("mid5/word", 64'(data_out), 64'(rev32(32'h960F_3C5A)));
    cyc(1'b0, 40'h0, 1'b1, "mid6");

`ifdef GEARBOX_N_TO_32_STATS_EN
    do_reset("stats");
    chk("stats/reset", 64'(underrun_count), 64'd0);
    valid_in = 1'b0;
    tx_ce    = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    chk("stats/saturate", 64'(underrun_count), 64'hFFFF);
    stats_clear = 1'b1;
    @(posedge clk);
    #1;
    chk("stats/clear", 64'(underrun_count), 64'd0);
    stats_clear = 1'b0;
    @(posedge clk);
    #1;
    chk("stats/count1", 64'(underrun_count), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
